sfx_scheduler: RTL and testbench

Plays sound-effect clips (hit, miss, countdown, game-over) from one shared waveform ROM for the Whack_mole audio path. It latches play requests from game logic and picks one clip by fixed priority, preempting the current clip when a higher-priority request arrives. It walks the clip's ROM addresses at the 4800 Hz sample rate and presents one held 16-bit signed sample to the audio output stage.

---
 rtl/sfx_scheduler.sv | 124 ++++++++++++
 tb/tb_sfx_scheduler.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/sfx_scheduler.sv
// Sound-effect clip scheduler: latches clip play requests, picks one by fixed priority
// (with preemption), walks that clip's ROM slot at the sample rate and holds each sample.
module sfx_scheduler #(
  parameter int          HOLD_TIME = 20_833,
  parameter int          CLIP_SLOT = 16_000,
  parameter logic [63:0] CLIP_LENS = {16'd9600, 16'd4800, 16'd2400, 16'd2400},
  parameter int          ROM_LAT   = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [3:0]  req,
  input  logic [15:0] rom_dout,
  output logic [16:0] rom_addr,
  output logic [15:0] sample,
  output logic        sample_valid,
  output logic        busy,
  output logic [1:0]  playing_id,
  output logic        done,
  output logic        state_dbg
);

  localparam int              HW        = (HOLD_TIME > 1) ? $clog2(HOLD_TIME) : 1;
  localparam int              IW        = $clog2(CLIP_SLOT + 1);
  localparam logic [HW-1:0]   HOLD_LAST = HW'(HOLD_TIME - 1);
  localparam logic [HW-1:0]   CAP_AT    = HW'(ROM_LAT);
  localparam logic [16:0]     SLOT      = 17'(CLIP_SLOT);

  typedef enum logic {IDLE = 1'b0, PLAY = 1'b1} state_t;

  state_t        state, state_n;
  logic [3:0]    pend, pend_n, cand;
  logic [1:0]    win, pid_n;
  logic [IW-1:0] idx, idx_n;
  logic [HW-1:0] hold, hold_n;
  logic [15:0]   sample_n, len;
  logic          sv_n, above, restart, preempt, last, done_c;

  // Handshake: req bits are single-cycle pulses with no back-pressure; a pulse is
  // either granted in the cycle it arrives or remembered in pend until served.
  assign cand     = en ? (pend | req) : 4'b0000;
  assign len      = CLIP_LENS[{playing_id, 4'b0000} +: 16];
  assign last     = (17'(idx) == (17'(len) - 17'd1));
  assign rom_addr = 17'(playing_id) * SLOT + 17'(idx);
  assign busy     = (state == PLAY);
  assign state_dbg = state;
  assign done     = done_c & ~rst;

  always_comb begin
    win   = 2'd0;
    above = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (cand[i]) win = 2'(i);
      if (cand[i] && (2'(i) > playing_id)) above = 1'b1;
    end
    restart = en & req[playing_id];
    preempt = (state == PLAY) && (above || restart);
  end

  always_comb begin
    state_n  = state;
    pend_n   = cand;
    pid_n    = playing_id;
    idx_n    = idx;
    hold_n   = hold;
    sample_n = sample;
    sv_n     = 1'b0;
    done_c   = 1'b0;
    if (!en) begin
      // idx is kept so rom_addr holds its last value while disabled
      state_n  = IDLE;
      pend_n   = 4'b0000;
      hold_n   = '0;
      sample_n = 16'd0;
    end else if ((state == IDLE && cand != 4'b0000) || preempt) begin
      state_n = PLAY;
      pid_n   = win;
      idx_n   = '0;
      hold_n  = '0;
      pend_n  = cand & ~(4'b0001 << win);
      if (state == IDLE) sample_n = 16'd0;
    end else if (state == IDLE) begin
      sample_n = 16'd0;
    end else begin
      if (hold == CAP_AT) begin
        sample_n = rom_dout;
        sv_n     = 1'b1;
      end
      if (hold == HOLD_LAST) begin
        if (last) begin
          state_n  = IDLE;
          done_c   = 1'b1;
          sample_n = 16'd0;
        end else begin
          idx_n  = idx + 1'b1;
          hold_n = '0;
        end
      end else begin
        hold_n = hold + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      pend         <= 4'b0000;
      playing_id   <= 2'd0;
      idx          <= '0;
      hold         <= '0;
      sample       <= 16'd0;
      sample_valid <= 1'b0;
    end else begin
      state        <= state_n;
      pend         <= pend_n;
      playing_id   <= pid_n;
      idx          <= idx_n;
      hold         <= hold_n;
      sample       <= sample_n;
      sample_valid <= sv_n;
    end
  end

endmodule

// File: tb/tb_sfx_scheduler.sv
// Bench for sfx_scheduler: small clip table, ROM whose word equals its address,
// expected samples queued at stimulus time and popped on sample_valid.
module tb_sfx_scheduler;

  localparam int          H    = 8;
  localparam int          SLOT = 16;
  localparam logic [63:0] LENS = {16'd5, 16'd2, 16'd4, 16'd3};

  logic        clk = 1'b0;
  logic        rst, en;
  logic [3:0]  req;
  logic [15:0] rom_dout, rom_p1;
  logic [16:0] rom_addr;
  logic [15:0] sample;
  logic        sample_valid, busy, done, state_dbg;
  logic [1:0]  playing_id;

  int          n_checks = 0;
  int          n_err    = 0;
  int          done_cnt = 0;
  logic [15:0] exp_q[$];
  logic [15:0] mon_e;

  sfx_scheduler #(
    .HOLD_TIME(H), .CLIP_SLOT(SLOT), .CLIP_LENS(LENS), .ROM_LAT(2)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .req(req), .rom_dout(rom_dout),
    .rom_addr(rom_addr), .sample(sample), .sample_valid(sample_valid),
    .busy(busy), .playing_id(playing_id), .done(done), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  // two-cycle ROM, word = address
  always @(posedge clk) begin
    rom_p1   <= rom_addr[15:0];
    rom_dout <= rom_p1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0d expected=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int clip_len(input int id);
    return int'(LENS[16*id +: 16]);
  endfunction

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_req(input logic [3:0] v);
    req = v;
    step(1);
    req = 4'b0000;
  endtask

  task automatic push_clip(input int id, input int cnt);
    for (int k = 0; k < cnt; k++) exp_q.push_back(16'(id * SLOT + k));
  endtask

  task automatic wait_done(input int budget, output int n);
    n = 0;
    while (!done && n < budget) begin
      step(1);
      n++;
    end
  endtask

  // scoreboard: every sample_valid must match the next queued value
  always @(negedge clk) begin
    if (!rst && sample_valid) begin
      if (exp_q.size() == 0) begin
        check("extra_sample", 32'(sample), 32'hFFFF_FFFF);
      end else begin
        mon_e = exp_q.pop_front();
        check("sample", 32'(sample), 32'(mon_e));
        check("sample_addr", 32'(rom_addr), 32'(mon_e));
      end
    end
    if (done) done_cnt++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n, d0;
    rst = 1'b1; en = 1'b1; req = 4'b0000;
    step(3);
    check("rst_addr", 32'(rom_addr), 0);
    check("rst_sample", 32'(sample), 0);
    check("rst_valid", 32'(sample_valid), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_pid", 32'(playing_id), 0);
    check("rst_done", 32'(done), 0);
    check("rst_state", 32'(state_dbg), 0);
    rst = 1'b0;
    step(1);

    // clip 0 plays to completion
    d0 = done_cnt;
    pulse_req(4'b0001);
    check("t1_busy", 32'(busy), 1);
    check("t1_addr", 32'(rom_addr), 0);
    push_clip(0, clip_len(0));
    wait_done(200, n);
    check("t1_done_at", n, clip_len(0) * H - 1);
    step(1);
    check("t1_busy_fall", 32'(busy), 0);
    check("t1_idle_sample", 32'(sample), 0);
    check("t1_done_cnt", done_cnt, d0 + 1);
    check("t1_q_empty", exp_q.size(), 0);

    // clip 2 preempts clip 0 during its second sample
    d0 = done_cnt;
    pulse_req(4'b0001);
    exp_q.push_back(16'd0);
    step(9);
    push_clip(2, clip_len(2));
    pulse_req(4'b0100);
    check("t2_addr", 32'(rom_addr), 32);
    check("t2_pid", 32'(playing_id), 2);
    check("t2_no_done", done_cnt, d0);
    wait_done(200, n);
    check("t2_done_at", n, clip_len(2) * H - 1);
    step(1);
    check("t2_busy_fall", 32'(busy), 0);
    check("t2_done_cnt", done_cnt, d0 + 1);

    // lower request waits, served one idle cycle after done
    d0 = done_cnt;
    pulse_req(4'b0100);
    push_clip(2, clip_len(2));
    step(3);
    pulse_req(4'b0010);
    check("t3_still_2", 32'(playing_id), 2);
    push_clip(1, clip_len(1));
    wait_done(200, n);
    step(1);
    check("t3_gap_busy", 32'(busy), 0);
    check("t3_gap_sample", 32'(sample), 0);
    step(1);
    check("t3_busy", 32'(busy), 1);
    check("t3_addr", 32'(rom_addr), 16);
    wait_done(200, n);
    check("t3_done_at", n, clip_len(1) * H - 1);
    step(1);
    check("t3_busy_fall", 32'(busy), 0);
    check("t3_done_cnt", done_cnt, d0 + 2);

    // clip 3 restarted by its own request at idx 3
    d0 = done_cnt;
    pulse_req(4'b1000);
    push_clip(3, 4);
    step(29);
    push_clip(3, clip_len(3));
    pulse_req(4'b1000);
    check("t4_addr", 32'(rom_addr), 48);
    check("t4_hold_sample", 32'(sample), 51);
    check("t4_no_done", done_cnt, d0);
    wait_done(200, n);
    check("t4_done_at", n, clip_len(3) * H - 1);
    step(1);
    check("t4_done_cnt", done_cnt, d0 + 1);

    // enable dropped with two clips pending
    d0 = done_cnt;
    pulse_req(4'b0100);
    exp_q.push_back(16'd32);
    pulse_req(4'b0011);
    step(3);
    en = 1'b0;
    step(1);
    check("t5_busy", 32'(busy), 0);
    check("t5_sample", 32'(sample), 0);
    check("t5_addr_kept", 32'(rom_addr), 32);
    pulse_req(4'b1000);
    check("t5_req_ignored", 32'(busy), 0);
    en = 1'b1;
    step(3);
    check("t5_pend_clear", 32'(busy), 0);
    check("t5_no_done", done_cnt, d0);

    // reset during playback
    pulse_req(4'b1000);
    exp_q.push_back(16'd48);
    pulse_req(4'b0001);
    step(4);
    rst = 1'b1;
    step(1);
    check("t6_addr", 32'(rom_addr), 0);
    check("t6_sample", 32'(sample), 0);
    check("t6_busy", 32'(busy), 0);
    check("t6_pid", 32'(playing_id), 0);
    check("t6_done", 32'(done), 0);
    rst = 1'b0;
    step(2);
    check("t6_pend_clear", 32'(busy), 0);
    d0 = done_cnt;
    pulse_req(4'b0010);
    check("t6_restart_addr", 32'(rom_addr), 16);
    push_clip(1, clip_len(1));
    wait_done(200, n);
    check("t6_done_at", n, clip_len(1) * H - 1);
    step(1);
    check("t6_done_cnt", done_cnt, d0 + 1);

    check("q_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
